game_turn_ctrl: RTL



---
 rtl/game_pkg.sv | 19 +
 rtl/turn_timer.sv | 26 ++
 rtl/game_turn_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and width helpers for the turn controller.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int pw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cw_f(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn cycle counter; expired is high on the last allowed cycle of a turn.
module turn_timer #(
  parameter int CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(CYCLES + 1);

  logic [TW-1:0] count;

  assign expired = enable && (count == TW'(CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= expired ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/game_turn_ctrl.sv
// Turn-based game sequencer: rotates players, counts moves, detects win/draw.
// Optional per-turn timeout via TURN_TIMEOUT_EN; all outputs registered.
module game_turn_ctrl import game_pkg::*; #(
  parameter  int NUM_PLAYERS    = 2,
  parameter  int NUM_CELLS      = 9,
  parameter  int MAX_ILLEGAL    = 3,
  parameter  int TIMEOUT_CYCLES = 1000,
  localparam int PW             = pw_f(NUM_PLAYERS),
  localparam int CW             = cw_f(NUM_CELLS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   move_valid,
  input  logic                   move_legal,
  input  logic                   win,
  output logic [1:0]             state,
  output logic [PW-1:0]          active_player,
  output logic [NUM_PLAYERS-1:0] turn_en,
  output logic                   move_ack,
  output logic                   move_reject,
  output logic                   timeout,
  output logic [CW-1:0]          moves_made,
  output logic                   game_over,
  output logic                   winner_valid,
  output logic [PW-1:0]          winner
);

  state_t        state_q;
  logic [3:0]    rej_cnt;
  logic          legal_move;
  logic          bad_move;
  logic          rej_limit;
  logic          expired;
  logic          forfeit;
  logic [PW-1:0] nxt_player;

  assign state      = state_q;
  assign legal_move = move_valid && move_legal;
  assign bad_move   = move_valid && !move_legal;
  assign rej_limit  = bad_move && (rej_cnt == 4'(MAX_ILLEGAL - 1));
  assign forfeit    = !legal_move && (rej_limit || expired);
  assign nxt_player = (active_player == PW'(NUM_PLAYERS - 1)) ? '0 : active_player + 1'b1;

`ifdef TURN_TIMEOUT_EN
  logic in_turn;
  logic tmr_clear;

  assign in_turn   = (state_q == TURN);
  // Timer restarts whenever the turn leaves the current player.
  assign tmr_clear = !in_turn || legal_move || rej_limit;

  turn_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (in_turn),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      timeout <= 1'b0;
    end else begin
      timeout <= in_turn && expired && !legal_move;
    end
  end
`else
  assign expired = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      active_player <= '0;
      turn_en       <= '0;
      move_ack      <= 1'b0;
      move_reject   <= 1'b0;
      moves_made    <= '0;
      game_over     <= 1'b0;
      winner_valid  <= 1'b0;
      winner        <= '0;
      rej_cnt       <= '0;
    end else begin
      move_ack    <= 1'b0;
      move_reject <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q       <= TURN;
            active_player <= '0;
            turn_en       <= NUM_PLAYERS'(1);
            moves_made    <= '0;
            game_over     <= 1'b0;
            winner_valid  <= 1'b0;
            winner        <= '0;
            rej_cnt       <= '0;
          end
        end
        TURN: begin
          if (legal_move) begin
            move_ack   <= 1'b1;
            moves_made <= moves_made + 1'b1;
            turn_en    <= '0;
            state_q    <= CHECK;
          end else begin
            move_reject <= bad_move;
            if (forfeit) begin
              active_player <= nxt_player;
              turn_en       <= NUM_PLAYERS'(1) << nxt_player;
              rej_cnt       <= '0;
            end else if (bad_move) begin
              rej_cnt <= rej_cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          if (win) begin
            state_q      <= DONE;
            game_over    <= 1'b1;
            winner_valid <= 1'b1;
            winner       <= active_player;
          end else if (moves_made == CW'(NUM_CELLS)) begin
            state_q   <= DONE;
            game_over <= 1'b1;
          end else begin
            state_q       <= TURN;
            active_player <= nxt_player;
            turn_en       <= NUM_PLAYERS'(1) << nxt_player;
            rej_cnt       <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          turn_en <= '0;
        end
      endcase
    end
  end

endmodule
